// File: rtl/wash_pkg.sv
// wash_pkg: shared state, phase/action codes and program duration tables for the
// washer scheduler.
`default_nettype none

package wash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_WASH  = 2'd1;
    localparam logic [1:0] PH_RINSE = 2'd2;
    localparam logic [1:0] PH_SPIN  = 2'd3;

    localparam logic [2:0] ACT_NONE     = 3'd0;
    localparam logic [2:0] ACT_ROTATE   = 3'd1;
    localparam logic [2:0] ACT_STEW     = 3'd2;
    localparam logic [2:0] ACT_ADDWATER = 3'd3;
    localparam logic [2:0] ACT_DRAIN    = 3'd4;
    localparam logic [2:0] ACT_FSPIN    = 3'd5;
    localparam logic [2:0] ACT_RSPIN    = 3'd6;
    localparam logic [2:0] ACT_END      = 3'd7;

    // Every phase of a program has the same length; spin-only is a single 15 s phase.
    function automatic logic [4:0] dur_of(input logic [1:0] mode);
        case (mode)
            2'b01:   return 5'd10;
            2'b10:   return 5'd15;
            2'b11:   return 5'd20;
            default: return 5'd15;
        endcase
    endfunction

    function automatic logic [7:0] total_bcd(input logic [1:0] mode);
        case (mode)
            2'b01:   return 8'h30;
            2'b10:   return 8'h45;
            2'b11:   return 8'h60;
            default: return 8'h15;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] ph);
        case (ph)
            PH_WASH:  return 2'd1;
            PH_RINSE: return 2'd2;
            PH_SPIN:  return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] act_of(input logic [1:0] ph, input logic [1:0] idx);
        case (ph)
            PH_WASH:  return idx[0] ? ACT_STEW : ACT_ROTATE;
            PH_RINSE: return (idx == 2'd0) ? ACT_ADDWATER :
                             (idx == 2'd1) ? ACT_ROTATE : ACT_DRAIN;
            PH_SPIN:  return (idx == 2'd0) ? ACT_FSPIN :
                             (idx == 2'd2) ? ACT_RSPIN : ACT_DRAIN;
            default:  return ACT_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down2.sv
// bcd_down2: two-digit BCD down-counter with parallel load and saturation at 00.
`default_nettype none

module bcd_down2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] val,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (load) begin
            tens <= val[7:4];
            ones <= val[3:0];
        end else if (dec && ({tens, ones} != 8'h00)) begin
            if (ones == 4'd0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wash_sched.sv
// wash_sched: washer program sequencer driving phase, action, remaining-time and
// door-lock outputs from a one-second tick.
`default_nettype none

module wash_sched
    import wash_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       door,
    input  logic [1:0] mode,
    output logic [1:0] phase,
    output logic [2:0] act,
    output logic [3:0] rem_t,
    output logic [3:0] rem_o,
    output logic       busy,
    output logic       lock,
    output logic       err,
    output logic       done
);

    state_t     state, state_n;
    logic [1:0] phase_n, mode_q, mode_n, idx, idx_n;
    logic [2:0] act_n;
    logic [4:0] cnt, cnt_n;
    logic       err_n, done_n;
    logic       rem_load, rem_dec;
    logic [7:0] rem_val;

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        act_n    = act;
        idx_n    = idx;
        cnt_n    = cnt;
        mode_n   = mode_q;
        err_n    = err;
        done_n   = 1'b0;
        rem_load = 1'b0;
        rem_dec  = 1'b0;
        rem_val  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (door) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = ST_RUN;
                        mode_n   = mode;
                        phase_n  = (mode == 2'b00) ? PH_SPIN : PH_WASH;
                        idx_n    = 2'd0;
                        act_n    = act_of(phase_n, 2'd0);
                        cnt_n    = dur_of(mode);
                        rem_load = 1'b1;
                        rem_val  = total_bcd(mode);
                        err_n    = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                // A hold request wins over a same-cycle tick; that tick is lost.
                if (pause || door) begin
                    state_n = ST_PAUSE;
                    if (door) err_n = 1'b1;
                end else if (tick) begin
                    rem_dec = 1'b1;
                    if (cnt == 5'd1) begin
                        if (phase == PH_SPIN) begin
                            state_n  = ST_DONE;
                            act_n    = ACT_END;
                            done_n   = 1'b1;
                            cnt_n    = 5'd0;
                            idx_n    = 2'd0;
                            rem_load = 1'b1;
                        end else begin
                            phase_n = phase + 2'd1;
                            idx_n   = 2'd0;
                            act_n   = act_of(phase_n, 2'd0);
                            cnt_n   = dur_of(mode_q);
                        end
                    end else begin
                        cnt_n = cnt - 5'd1;
                        idx_n = (idx == last_idx(phase)) ? 2'd0 : idx + 2'd1;
                        act_n = act_of(phase, idx_n);
                    end
                end
            end
            ST_PAUSE: begin
                if (start && !pause && !door) begin
                    state_n = ST_RUN;
                    err_n   = 1'b0;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n  = ST_IDLE;
                    phase_n  = PH_SETUP;
                    act_n    = ACT_NONE;
                    rem_load = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            phase  <= PH_SETUP;
            act    <= ACT_NONE;
            idx    <= 2'd0;
            cnt    <= 5'd0;
            mode_q <= 2'd0;
            err    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            lock   <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            act    <= act_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            err    <= err_n;
            done   <= done_n;
            busy   <= (state_n == ST_RUN) || (state_n == ST_PAUSE);
            lock   <= (state_n == ST_RUN);
        end
    end

    bcd_down2 u_rem (
        .clk  (clk),
        .rst  (rst),
        .load (rem_load),
        .val  (rem_val),
        .dec  (rem_dec),
        .tens (rem_t),
        .ones (rem_o)
    );

endmodule

`default_nettype wire
